// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported main memory between the
// instruction-fetch requester (read-only) and the data requester (read/write).
module mem_port_arbiter #(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        if_rsp_ready,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  input  logic        d_rsp_ready,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable
);

  localparam logic PREFER_IF = 1'b0;
  localparam logic PREFER_D  = 1'b1;

  logic rr_ptr;
  logic if_free, d_free;
  logic if_elig, d_elig;
  logic grant_if, grant_d;
  logic if_in_range, d_in_range;

  // Handshakes: a transfer happens on the cycle valid && ready are both high;
  // requests hold still while waiting, and a response stays put until its ready.
  assign if_free     = !if_rsp_valid || if_rsp_ready;
  assign d_free      = !d_rsp_valid || d_rsp_ready;
  assign if_elig     = if_req_valid && if_free;
  assign d_elig      = d_req_valid && d_free;
  assign if_in_range = if_req_addr < 32'(DEPTH);
  assign d_in_range  = d_req_addr < 32'(DEPTH);

  // Gating with rst_n keeps a write from landing while reset is asserted.
  assign grant_if = rst_n && if_elig && (!d_elig || (rr_ptr == PREFER_IF));
  assign grant_d  = rst_n && d_elig && (!if_elig || (rr_ptr == PREFER_D));

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  always_comb begin
    mem_read_address = '0;
    if (grant_if) begin
      mem_read_address = if_req_addr;
    end else if (grant_d) begin
      mem_read_address = d_req_addr;
    end
  end

  assign mem_write_address = d_req_addr;
  assign mem_write_data    = d_req_wdata;
  assign mem_write_enable  = grant_d && d_req_we && d_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PREFER_IF;
    end else if (grant_if) begin
      rr_ptr <= PREFER_D;
    end else if (grant_d) begin
      rr_ptr <= PREFER_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
    end else if (grant_if) begin
      if_rsp_valid <= 1'b1;
      if_rsp_data  <= if_in_range ? mem_read_data : '0;
      if_rsp_err   <= !if_in_range;
    end else if (if_rsp_ready) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
    end
  end

  // Writes answer with zero data; only reads return the memory word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_err   <= 1'b0;
    end else if (grant_d) begin
      d_rsp_valid <= 1'b1;
      d_rsp_data  <= (d_in_range && !d_req_we) ? mem_read_data : '0;
      d_rsp_err   <= !d_in_range;
    end else if (d_rsp_ready) begin
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: attached memory, arbitration/response model with
// expected-response queues, a vector table and hand-written corner sequences.
module tb_mem_port_arbiter;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_req_addr = '0;
  logic        if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        if_rsp_ready = 1'b1;
  logic        d_req_valid = 1'b0, d_req_ready;
  logic [31:0] d_req_addr = '0, d_req_wdata = '0;
  logic        d_req_we = 1'b0;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_data;
  logic        d_rsp_ready = 1'b1;
  logic [31:0] mem_read_address, mem_read_data;
  logic [31:0] mem_write_address, mem_write_data;
  logic        mem_write_enable;

  mem_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .if_rsp_ready(if_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .d_rsp_ready(d_rsp_ready),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters and check ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  // ---------------- attached memory (comb read, sync write) ----------------
  logic [31:0] mem [DEPTH];
  assign mem_read_data = (mem_read_address < 32'(DEPTH)) ? mem[mem_read_address[10:0]]
                                                         : 32'hBAD0_BAD0;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write_enable) mem[mem_write_address[10:0]] <= mem_write_data;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [DEPTH];
  logic [32:0] exp_if_q[$];
  logic [32:0] exp_d_q[$];
  logic m_ptr = 1'b0, m_if_v = 1'b0, m_d_v = 1'b0, if_new = 1'b0, d_new = 1'b0;
  logic [31:0] m_if_d = '0, m_d_d = '0;
  logic m_if_e = 1'b0, m_d_e = 1'b0;
  logic e_gi = 1'b0, e_gd = 1'b0, e_if_el, e_d_el;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ptr = 1'b0; m_if_v = 1'b0; m_d_v = 1'b0; if_new = 1'b0; d_new = 1'b0;
        exp_if_q.delete(); exp_d_q.delete();
      end else begin
        if_new = e_gi;
        d_new  = e_gd;
        if (e_gi) begin
          m_if_v = 1'b1;
          m_ptr  = 1'b1;
          if (if_req_addr < 32'(DEPTH)) exp_if_q.push_back({1'b0, ref_mem[if_req_addr[10:0]]});
          else exp_if_q.push_back({1'b1, 32'h0});
        end else if (if_rsp_ready) begin
          m_if_v = 1'b0;
        end
        if (e_gd) begin
          m_d_v = 1'b1;
          m_ptr = 1'b0;
          if (d_req_addr >= 32'(DEPTH)) exp_d_q.push_back({1'b1, 32'h0});
          else if (d_req_we) begin
            exp_d_q.push_back({1'b0, 32'h0});
            ref_mem[d_req_addr[10:0]] = d_req_wdata;
          end else exp_d_q.push_back({1'b0, ref_mem[d_req_addr[10:0]]});
        end else if (d_rsp_ready) begin
          m_d_v = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    e_if_el = if_req_valid && (!m_if_v || if_rsp_ready);
    e_d_el  = d_req_valid && (!m_d_v || d_rsp_ready);
    e_gi = rst_n && e_if_el && (!e_d_el || !m_ptr);
    e_gd = rst_n && e_d_el && (!e_if_el || m_ptr);
    chk("if_req_ready", 32'(if_req_ready), 32'(e_gi));
    chk("d_req_ready", 32'(d_req_ready), 32'(e_gd));
    chk("mem_write_enable", 32'(mem_write_enable),
        32'(e_gd && d_req_we && (d_req_addr < 32'(DEPTH))));
    chk("mem_read_address", mem_read_address, e_gi ? if_req_addr : (e_gd ? d_req_addr : 32'h0));
    if (e_gd && d_req_we) begin
      chk("mem_write_address", mem_write_address, d_req_addr);
      chk("mem_write_data", mem_write_data, d_req_wdata);
    end
    if (if_new) begin
      if_new = 1'b0;
      if (exp_if_q.size() == 0) begin
        total++; bad++;
        $display("FAIL if_rsp_queue: response due but no expected entry at %0t", $time);
      end else {m_if_e, m_if_d} = exp_if_q.pop_front();
    end
    if (d_new) begin
      d_new = 1'b0;
      if (exp_d_q.size() == 0) begin
        total++; bad++;
        $display("FAIL d_rsp_queue: response due but no expected entry at %0t", $time);
      end else {m_d_e, m_d_d} = exp_d_q.pop_front();
    end
    chk("if_rsp_valid", 32'(if_rsp_valid), 32'(m_if_v));
    chk("if_rsp_data", if_rsp_data, m_if_v ? m_if_d : 32'h0);
    chk("if_rsp_err", 32'(if_rsp_err), 32'(m_if_v && m_if_e));
    chk("d_rsp_valid", 32'(d_rsp_valid), 32'(m_d_v));
    chk("d_rsp_data", d_rsp_data, m_d_v ? m_d_d : 32'h0);
    chk("d_rsp_err", 32'(d_rsp_err), 32'(m_d_v && m_d_e));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [31:0] a, input logic rr);
    if_req_valid = v; if_req_addr = a; if_rsp_ready = rr;
  endtask

  task automatic set_d(input logic v, input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic rr);
    d_req_valid = v; d_req_addr = a; d_req_we = we; d_req_wdata = wd; d_rsp_ready = rr;
  endtask

  function automatic logic [31:0] rand_addr(input logic for_write);
    if ($urandom_range(0, 9) == 0) return 32'(DEPTH - 1) + 32'($urandom_range(0, 2));
    return for_write ? 32'($urandom_range(16, 31)) : 32'($urandom_range(0, 31));
  endfunction

  task automatic rand_cycle();
    logic hold_if, hold_d;
    tick();
    hold_if = if_req_valid && !e_gi;
    hold_d  = d_req_valid && !e_gd;
    if (!hold_if) begin
      if_req_valid = ($urandom_range(0, 2) != 0);
      if_req_addr  = rand_addr(1'b0);
    end
    if (!hold_d) begin
      d_req_valid = ($urandom_range(0, 2) != 0);
      d_req_we    = 1'($urandom_range(0, 1));
      d_req_addr  = rand_addr(d_req_we);
      d_req_wdata = $urandom;
    end
    if_rsp_ready = ($urandom_range(0, 3) != 0);
    d_rsp_ready  = ($urandom_range(0, 3) != 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        if_v;
    logic [31:0] if_a;
    logic        d_v;
    logic [31:0] d_a;
    logic        d_we;
    logic [31:0] d_wd;
    logic        x_if_rdy;
    logic        x_d_rdy;
    logic        x_mwe;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic dv,
                              input logic [31:0] da, input logic we, input logic [31:0] wd,
                              input logic xi, input logic xd, input logic xw);
    vec_t v;
    v.if_v = iv; v.if_a = ia; v.d_v = dv; v.d_a = da; v.d_we = we; v.d_wd = wd;
    v.x_if_rdy = xi; v.x_d_rdy = xd; v.x_mwe = xw;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    tbl[0] = mk(1'b1, 32'd10, 1'b1, 32'd20,   1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
    tbl[1] = mk(1'b1, 32'd11, 1'b1, 32'd20,   1'b0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[2] = mk(1'b1, 32'd11, 1'b1, 32'd21,   1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
    tbl[3] = mk(1'b1, 32'd12, 1'b1, 32'd21,   1'b0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[4] = mk(1'b1, 32'd12, 1'b1, 32'd5,    1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 1'b0);
    tbl[5] = mk(1'b0, 32'd0,  1'b1, 32'd5,    1'b1, 32'hDEADBEEF,  1'b0, 1'b1, 1'b1);
    tbl[6] = mk(1'b1, 32'd5,  1'b0, 32'd0,    1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
    tbl[7] = mk(1'b0, 32'd0,  1'b1, 32'd2048, 1'b1, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
    tbl[8] = mk(1'b0, 32'd0,  1'b1, 32'd2048, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0);
    tbl[9] = mk(1'b0, 32'd0,  1'b0, 32'd0,    1'b0, 32'h0,         1'b0, 1'b0, 1'b0);

    // Reset with both requesters asserting, including an in-range write.
    set_if(1'b1, 32'd1, 1'b1);
    set_d(1'b1, 32'd3, 1'b1, 32'h5555_AAAA, 1'b1);
    repeat (2) @(negedge clk);
    chk("reset_if_req_ready", 32'(if_req_ready), 32'd0);
    chk("reset_d_req_ready", 32'(d_req_ready), 32'd0);
    chk("reset_mem_write_enable", 32'(mem_write_enable), 32'd0);
    chk("reset_rsp_valids", {30'd0, if_rsp_valid, d_rsp_valid}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      tick();
      rst_n = 1'b1;
      set_if(tbl[i].if_v, tbl[i].if_a, 1'b1);
      set_d(tbl[i].d_v, tbl[i].d_a, tbl[i].d_we, tbl[i].d_wd, 1'b1);
      @(negedge clk);
      chk($sformatf("tbl%0d_if_ready", i), 32'(if_req_ready), 32'(tbl[i].x_if_rdy));
      chk($sformatf("tbl%0d_d_ready", i), 32'(d_req_ready), 32'(tbl[i].x_d_rdy));
      chk($sformatf("tbl%0d_mwe", i), 32'(mem_write_enable), 32'(tbl[i].x_mwe));
      if (i == 6) chk("write_rsp", {d_rsp_data[29:0], d_rsp_valid, d_rsp_err}, 32'h2);
      if (i == 7) chk("read_after_write", if_rsp_data, 32'hDEADBEEF);
      if (i == 8 || i == 9) chk($sformatf("oor_rsp%0d", i), {d_rsp_data[29:0], d_rsp_valid, d_rsp_err}, 32'h3);
    end

    // Fetch response held for three cycles while data keeps being granted.
    tick(); set_if(1'b1, 32'd7, 1'b0); set_d(1'b1, 32'd30, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("hold_c0_if_ready", 32'(if_req_ready), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick(); set_if(1'b1, 32'd8, 1'b0); set_d(1'b1, 32'(30 + c), 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk($sformatf("hold_c%0d_ready", c), {30'd0, if_req_ready, d_req_ready}, 32'd1);
      chk($sformatf("hold_c%0d_data", c), if_rsp_data, init_word(7));
      chk($sformatf("hold_c%0d_valid", c), 32'(if_rsp_valid), 32'd1);
    end
    tick(); set_if(1'b1, 32'd8, 1'b1); set_d(1'b1, 32'd34, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("hold_release_if_ready", 32'(if_req_ready), 32'd1);
    tick(); set_if(1'b0, 32'd0, 1'b1); set_d(1'b0, 32'd0, 1'b0, 32'h0, 1'b1);

    // Back-to-back fetch reads of words 0..3 with the data port idle.
    for (int k = 0; k <= 4; k++) begin
      tick();
      set_if(k < 4, 32'(k), 1'b1);
      @(negedge clk);
      if (k < 4) chk($sformatf("b2b_ready%0d", k), 32'(if_req_ready), 32'd1);
      if (k > 0) begin
        chk($sformatf("b2b_valid%0d", k - 1), 32'(if_rsp_valid), 32'd1);
        chk($sformatf("b2b_data%0d", k - 1), if_rsp_data, init_word(k - 1));
      end
    end

    repeat (300) rand_cycle();

    // Reset asserted in the same cycle as a write request to word 6.
    tick();
    rst_n = 1'b0;
    set_if(1'b0, 32'd0, 1'b1);
    set_d(1'b1, 32'd6, 1'b1, 32'h6666_6666, 1'b1);
    @(negedge clk);
    chk("midreset_mwe", 32'(mem_write_enable), 32'd0);
    chk("midreset_d_ready", 32'(d_req_ready), 32'd0);
    chk("midreset_rsp_valids", {30'd0, if_rsp_valid, d_rsp_valid}, 32'd0);
    tick(); rst_n = 1'b1; set_d(1'b0, 32'd0, 1'b0, 32'h0, 1'b1); set_if(1'b1, 32'd6, 1'b1);
    @(negedge clk); chk("postreset_if_ready", 32'(if_req_ready), 32'd1);
    tick(); set_if(1'b0, 32'd0, 1'b1);
    @(negedge clk); chk("postreset_word6", if_rsp_data, init_word(6));

    repeat (3) tick();
    @(negedge clk);
    chk("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
    chk("d_queue_drained", 32'(exp_d_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported main memory between the instruction-fetch requester (read-only) and the data requester (read/write).
- Each requester uses a valid/ready request channel and a registered valid/ready response channel.
- At most one memory access is granted per cycle, chosen round-robin, and is driven onto the memory's combinational-read / synchronous-write ports.
- Sits between the CPU front-end/LSU and main_memory.

Parameters:
- DEPTH, 2048, number of 32-bit words in the attached memory; word-index addresses at or above DEPTH are out of range.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request present
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  32  fetch word index
- if_rsp_valid  out  1  fetch response held
- if_rsp_data  out  32  fetch read data
- if_rsp_err  out  1  fetch address was out of range
- if_rsp_ready  in  1  fetch response consumed
- d_req_valid  in  1  data request present
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  32  data word index
- d_req_we  in  1  1 = write, 0 = read
- d_req_wdata  in  32  write data
- d_rsp_valid  out  1  data response held
- d_rsp_data  out  32  read data; 0 for writes
- d_rsp_err  out  1  data address was out of range
- d_rsp_ready  in  1  data response consumed
- mem_read_address  out  32  to memory read port
- mem_read_data  in  32  combinational read data from memory
- mem_write_address  out  32  to memory write port
- mem_write_data  out  32  to memory write port
- mem_write_enable  out  1  to memory write enable

Behaviour:
- Reset (async, rst_n low):
  - if_rsp_valid, d_rsp_valid, both *_rsp_data and both *_rsp_err go to 0.
  - The round-robin pointer goes to "fetch preferred".
  - All grants are forced to 0 while rst_n is low, so *_req_ready and mem_write_enable are 0 combinationally.
- Slot free (per port): rsp_valid==0, or rsp_valid==1 with rsp_ready==1 in the same cycle, so responses can pass through back-to-back.
- Eligible: req_valid && slot free.
- Arbitration is combinational each cycle:
  - Only one port eligible: grant it.
  - Both eligible: grant the port the pointer prefers.
  - On any grant, the pointer flips to prefer the other port at the posedge.
  - No grant: pointer holds.
- req_ready is exactly that port's grant. The handshake completes when valid && ready.
- Requesters must hold addr, we and wdata stable while valid && !ready. The arbiter never drops a request.
- Starvation bound: a continuously eligible port is granted within 2 cycles.
- Memory drive:
  - mem_read_address = granted addr; 0 when idle.
  - mem_write_address and mem_write_data = d_req_addr and d_req_wdata.
  - mem_write_enable = data grant && d_req_we && in range.
- Read latency:
  - mem_read_data is sampled at the posedge ending the grant cycle into that port's rsp_data.
  - rsp_valid rises the next cycle: 1-cycle latency from handshake to response.
- Write:
  - Commits at the grant posedge.
  - d_rsp_valid rises next cycle with d_rsp_data = 0.
  - A read granted in the following cycle returns the new data.
- Out of range (addr >= DEPTH):
  - Write is suppressed and read data is forced to 0.
  - The response is still issued, with rsp_err = 1.
- Response hold: rsp_valid, rsp_data and rsp_err stay stable until rsp_ready. They are cleared on rsp_ready unless a new response loads in the same edge, in which case the new response wins.
- Reset asserted mid-operation: any pending response is discarded. A write granted in the same cycle as the reset assertion does not commit, because the enable is forced low.

Test Plan:
- Reset with both req_valid high -> both req_ready=0, mem_write_enable=0, both rsp_valid=0. After release, first cycle grants fetch (if_req_ready=1, d_req_ready=0).
- Both ports requesting continuously, both rsp_ready=1 -> grants alternate IF, D, IF, D. Each port sees rsp_valid one cycle after its handshake.
- Data write addr 5 data 0xDEADBEEF, then fetch read addr 5 next cycle -> mem_write_enable=1 in the write cycle; d_rsp_data=0, d_rsp_err=0; if_rsp_data=0xDEADBEEF.
- Fetch with if_rsp_ready=0 for 3 cycles -> if_rsp_valid held with stable data; further fetch requests see if_req_ready=0. Data port continues to be granted every cycle.
- Data write to addr 2048 (DEPTH) -> mem_write_enable=0, d_rsp_err=1. A subsequent read of addr 2048 returns data 0 with err=1.
- Back-to-back fetch reads addr 0..3 with if_rsp_ready=1 and data idle -> one grant per cycle, four consecutive response cycles, data matching memory contents.
